dmem_req_ctrl: RTL and testbench
================================

# dmem_req_ctrl

Memory-stage request initiator sitting between the pipeline's MEM stage and `dmem_top`. Accepts one load/store per request from the pipeline and drives `dmem_top`'s aligned-only port, with two jobs: hiding the one-cycle synchronous BRAM read latency behind a stall, and splitting misaligned accesses into a sequence of aligned byte accesses. Returns load data, reassembled and sign/zero-extended per `func3`, with a response strobe.

## Interface
No parameters. Data width is 64 and address width is 64, both fixed.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: pipeline request present. `req_*` stay stable while `stall`=1.
- `req_we` in 1: 1=store, 0=load.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data, right-justified.
- `req_func3` in 3: RV64I width/sign. Loads use 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Stores use 000–011.
- `stall` out 1: hold the pipeline this cycle.
- `rsp_valid` out 1: request completes this cycle.
- `rsp_rdata` out 64: load result, valid with `rsp_valid` on loads. 0 on stores.
- `mem_we` out 1: to `dmem_top.we`.
- `mem_re` out 1: to `dmem_top.re`.
- `mem_addr` out 64: to `dmem_top.addr`.
- `mem_wdata` out 64: to `dmem_top.data`.
- `mem_func3` out 3: to `dmem_top.func3`.
- `mem_rdata` in 64: from `dmem_top.out_data`. Valid the cycle after `mem_re`.

## Operation
- Access size is n = 1 << `req_func3[1:0]`.
- An access is misaligned when (`req_addr` & (n−1)) ≠ 0.
- `req_func3`=111 is illegal:
  - no memory access is made;
  - `rsp_valid`=1 in cycle 0 with `rsp_rdata`=0 and `stall`=0.
- FSM states:
  - **IDLE**:
    - Aligned store: drive `mem_we`=1 with addr, wdata and func3 passed through. Complete in cycle 0. Stay in IDLE.
    - Aligned load: drive `mem_re`=1 and go to **ALD_WAIT**.
    - Misaligned access: perform byte 0, set k=1 and go to **SPLIT**.
  - **ALD_WAIT**:
    - `rsp_rdata` = `mem_rdata` (the load unit has already extended it).
    - Assert `rsp_valid` and go to IDLE.
  - **SPLIT**, one byte per cycle, with counter k (3 bits):
    - Issue `mem_addr` = `req_addr`+k (modulo 2^64, so wrap-around is legal).
    - Issue `mem_func3` = 000 for stores and 100 (LBU) for loads.
    - `mem_wdata` = `req_wdata` >> 8k.
    - Load bytes returned in `mem_rdata[7:0]` are shifted into byte buffer lane k−1.
    - Store: complete when k = n−1 is written (`rsp_valid` that cycle), then go to IDLE.
    - Load: after issuing k = n−1, go to **SPLIT_LAST**.
  - **SPLIT_LAST**:
    - Merge the final byte into lane n−1.
    - Sign-extend for func3 0xx, zero-extend for func3 1xx.
    - Assert `rsp_valid` and go to IDLE.
- Handshake: `stall` = `req_valid` & ¬`rsp_valid`.
- When `req_valid`=0 in IDLE: all mem strobes are 0, `stall`=0, `rsp_valid`=0.
- Back-to-back requests: a new request may appear in the cycle after `rsp_valid` and is handled from IDLE with no bubble.
- Reset:
  - State returns to IDLE, k=0, byte buffer=0.
  - While `rst`=1: `stall`, `rsp_valid`, `mem_we` and `mem_re` are all 0.
  - Reset mid-split abandons the access. Bytes already stored stay written, and a held request restarts from byte 0.

## Timing
Cycle 0 is the first cycle `req_valid`=1 in IDLE.

| Access | `rsp_valid` cycle | Stall cycles |
|---|---|---|
| Aligned store | 0 | 0 |
| Aligned load | 1 | 1 |
| Misaligned store | n−1 | n−1 |
| Misaligned load | n | n |

- Misaligned load: byte k is issued in cycle k and its data is sampled in cycle k+1.
- `mem_*` outputs are combinational from state, k and `req_*`.
- `rsp_rdata` is combinational from `mem_rdata` and the buffer.

## Structure
- Shared package `dmem_pkg`:
  - func3 constants (F3_B/H/W/D/BU/HU/WU);
  - FSM state enum;
  - size function n(func3).
  - `dmem_top` users also import it.
- One sub-module, `byte_assembler`: buffer lanes, final-byte merge, and sign/zero extension by func3.
- FSM and counter stay in the top.

## Test plan
- **Aligned LD:** `req_addr`=0x100 after storing 0x1122334455667788 there.
  - Cycle 0: `stall`=1, `mem_re`=1.
  - Cycle 1: `rsp_valid`=1, `rsp_rdata`=0x1122334455667788.
- **Misaligned SW:** 0xAABBCCDD at 0x103.
  - Cycles 0–3 emit byte stores DD, CC, BB, AA to 0x103–0x106.
  - `stall`=1 for cycles 0–2.
  - `rsp_valid` in cycle 3.
- **Misaligned LH:** at 0x107, with bytes 0x34 at 0x107 and 0x80 at 0x108.
  - `rsp_rdata`=0xFFFFFFFFFFFF8034 in cycle 2.
  - The same access with LHU gives 0x8034.
- **Address wrap:** LW at 0xFFFFFFFFFFFFFFFE.
  - Byte addresses issued: …FE, …FF, 0x0, 0x1.
- **Reset:** `rst` asserted in cycle 2 of a misaligned SD.
  - Next cycle: IDLE with `stall`=0.
  - The re-presented request restarts at byte 0 and completes in 8 cycles.
- **Illegal func3 and back-to-back:**
  - func3=111 gives an immediate `rsp_valid` with no `mem_we`/`mem_re`.
  - An aligned SB followed by an aligned LB in consecutive cycles completes with no bubble.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory path: RV64I load/store width codes,
// the request-controller FSM states and access-size helpers.
// Imported by dmem_req_ctrl, its byte assembler and dmem_top users.
package dmem_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALD_WAIT,
    ST_SPLIT,
    ST_SPLIT_LAST
  } state_t;

  // Access size in bytes from the width bits func3[1:0].
  function automatic logic [3:0] access_size(input logic [1:0] size_code);
    return 4'd1 << size_code;
  endfunction

  // Index of the last byte lane of an access (n-1).
  function automatic logic [2:0] last_lane(input logic [1:0] size_code);
    return 3'(access_size(size_code) - 4'd1);
  endfunction

endpackage

// File: rtl/dmem_req_ctrl_if.sv
// Bundle between the pipeline MEM stage, dmem_req_ctrl and dmem_top.
// Carries request/response (req_*, stall, rsp_*) and the aligned memory port (mem_*).
// slave = the controller; master = the pipeline/memory side driving it.
interface dmem_req_ctrl_if;
  import dmem_pkg::*;

  logic            req_valid;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [2:0]      req_func3;
  logic            stall;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            mem_we;
  logic            mem_re;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [2:0]      mem_func3;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_func3, mem_rdata,
    output stall, rsp_valid, rsp_rdata, mem_we, mem_re, mem_addr, mem_wdata, mem_func3
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_func3, mem_rdata,
    input  stall, rsp_valid, rsp_rdata, mem_we, mem_re, mem_addr, mem_wdata, mem_func3
  );

endinterface

// File: rtl/byte_assembler.sv
// Collects bytes of a split load into lanes, merges the final byte and extends by func3.
// Ports: clk/rst, cap + cap_lane + byte_in (lane write), func3 (width/sign), data (result).
// Result is combinational from the lanes and byte_in; the last lane bypasses the buffer.
module byte_assembler
  import dmem_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            cap,
  input  logic [2:0]      cap_lane,
  input  logic [7:0]      byte_in,
  input  logic [2:0]      func3,
  output logic [XLEN-1:0] data
);

  logic [7:0][7:0] lane_q;
  logic [7:0][7:0] merged;
  logic [XLEN-1:0] m;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
    end else if (cap) begin
      lane_q[cap_lane] <= byte_in;
    end
  end

  // Lanes above n-1 may hold stale bytes from a wider earlier access;
  // the extension below discards them.
  always_comb begin
    merged = lane_q;
    merged[last_lane(func3[1:0])] = byte_in;
    m = merged;
    case (func3)
      F3_B:    data = {{56{m[7]}},  m[7:0]};
      F3_H:    data = {{48{m[15]}}, m[15:0]};
      F3_W:    data = {{32{m[31]}}, m[31:0]};
      F3_BU:   data = {56'd0, m[7:0]};
      F3_HU:   data = {48'd0, m[15:0]};
      F3_WU:   data = {32'd0, m[31:0]};
      default: data = m;
    endcase
  end

endmodule

// File: rtl/dmem_req_ctrl.sv
// MEM-stage request initiator: hides BRAM read latency and splits misaligned accesses into bytes.
// Ports: clk, rst (sync, active-high), bus (slave modport: req_*/stall/rsp_* and mem_* port).
// Latency: aligned store 0, aligned load 1, misaligned store n-1, misaligned load n cycles.
module dmem_req_ctrl
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  dmem_req_ctrl_if.slave bus
);

  state_t          state_q, state_d;
  logic [2:0]      k_q, k_d;

  logic [2:0]      n_last;
  logic            illegal;
  logic            misaligned;
  logic [2:0]      split_f3;

  logic            mem_we_c, mem_re_c, rsp_valid_c;
  logic [XLEN-1:0] mem_addr_c, mem_wdata_c, rsp_rdata_c;
  logic [2:0]      mem_func3_c;
  logic            cap;
  logic [XLEN-1:0] asm_data;

  byte_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .cap      (cap),
    .cap_lane (k_q - 3'd1),
    .byte_in  (bus.mem_rdata[7:0]),
    .func3    (bus.req_func3),
    .data     (asm_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    n_last      = last_lane(bus.req_func3[1:0]);
    illegal     = (bus.req_func3 == F3_ILL);
    misaligned  = (bus.req_addr[2:0] & n_last) != 3'd0;
    split_f3    = bus.req_we ? F3_B : F3_BU;

    state_d     = state_q;
    k_d         = k_q;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_addr_c  = bus.req_addr;
    mem_wdata_c = bus.req_wdata;
    mem_func3_c = bus.req_func3;
    rsp_valid_c = 1'b0;
    rsp_rdata_c = '0;
    cap         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (illegal) begin
            rsp_valid_c = 1'b1;
          end else if (misaligned) begin
            // Byte 0 goes out now, from the unmodified address and data.
            mem_we_c    = bus.req_we;
            mem_re_c    = !bus.req_we;
            mem_func3_c = split_f3;
            k_d         = 3'd1;
            state_d     = ST_SPLIT;
          end else if (bus.req_we) begin
            mem_we_c    = 1'b1;
            rsp_valid_c = 1'b1;
          end else begin
            mem_re_c    = 1'b1;
            state_d     = ST_ALD_WAIT;
          end
        end
      end

      ST_ALD_WAIT: begin
        rsp_valid_c = 1'b1;
        rsp_rdata_c = bus.mem_rdata;
        state_d     = ST_IDLE;
      end

      ST_SPLIT: begin
        mem_addr_c  = bus.req_addr + {61'd0, k_q};
        mem_wdata_c = bus.req_wdata >> {k_q, 3'b000};
        mem_func3_c = split_f3;
        mem_we_c    = bus.req_we;
        mem_re_c    = !bus.req_we;
        // Data for byte k-1 arrives now, one cycle behind its issue.
        cap         = !bus.req_we;
        if (k_q == n_last) begin
          k_d = 3'd0;
          if (bus.req_we) begin
            rsp_valid_c = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d     = ST_SPLIT_LAST;
          end
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      ST_SPLIT_LAST: begin
        rsp_valid_c = 1'b1;
        rsp_rdata_c = asm_data;
        k_d         = 3'd0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  assign bus.mem_we    = mem_we_c & ~rst;
  assign bus.mem_re    = mem_re_c & ~rst;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_func3 = mem_func3_c;
  assign bus.rsp_valid = rsp_valid_c & ~rst;
  assign bus.rsp_rdata = rsp_rdata_c;
  assign bus.stall     = bus.req_valid & ~rsp_valid_c & ~rst;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl with a byte-addressed memory stand-in for dmem_top.
// Expected latency and load data come from a reference byte memory and the access-size rules.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_req_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_req_ctrl_if bus ();

  dmem_req_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] phys_mem [logic [63:0]];
  logic [7:0] ref_mem  [logic [63:0]];

  logic [63:0] iss_addr [$];
  logic [7:0]  iss_byte [$];
  logic [2:0]  iss_f3   [$];

  int          lat;
  logic [63:0] rd;
  logic        st_ok, f_re, f_we;

  function automatic logic [7:0] rd_phys(input logic [63:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] rd_ref(input logic [63:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Extension by shifting the value to the top and back down.
  function automatic logic [63:0] extend(input logic [63:0] v, input logic [2:0] f3);
    int sh;
    if (f3 == 3'b111) return 64'd0;
    sh = 64 - 8 * size_of(f3);
    if (f3[2]) return (v << sh) >> sh;
    return 64'($signed(v << sh) >>> sh);
  endfunction

  function automatic logic [63:0] load_ref(input logic [63:0] a, input logic [2:0] f3);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < size_of(f3); i++) v = v | (64'(rd_ref(a + 64'(i))) << (8 * i));
    return extend(v, f3);
  endfunction

  function automatic logic [63:0] load_phys(input logic [63:0] a, input logic [2:0] f3);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < size_of(f3); i++) v = v | (64'(rd_phys(a + 64'(i))) << (8 * i));
    return extend(v, f3);
  endfunction

  function automatic int exp_lat(input logic we, input logic [63:0] a, input logic [2:0] f3);
    int n;
    if (f3 == 3'b111) return 0;
    n = size_of(f3);
    if ((a % 64'(n)) == 64'd0) return we ? 0 : 1;
    return we ? n - 1 : n;
  endfunction

  // dmem_top stand-in: aligned accesses, one-cycle synchronous read.
  always @(posedge clk) begin
    if (bus.mem_we)
      for (int i = 0; i < size_of(bus.mem_func3); i++)
        phys_mem[bus.mem_addr + 64'(i)] = bus.mem_wdata[8*i +: 8];
    if (bus.mem_re)
      bus.mem_rdata <= load_phys(bus.mem_addr, bus.mem_func3);
  end

  // Presents one request and follows it to its response (bounded), logging memory traffic.
  task automatic run_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [2:0] f3, output int l, output logic [63:0] r,
                         output logic ok, output logic fre, output logic fwe);
    iss_addr.delete(); iss_byte.delete(); iss_f3.delete();
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_func3 = f3;
    l = -1; r = 64'd0; ok = 1'b1; fre = 1'b0; fwe = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin fre = bus.mem_re; fwe = bus.mem_we; end
      if (bus.mem_we || bus.mem_re) begin
        iss_addr.push_back(bus.mem_addr);
        iss_byte.push_back(bus.mem_wdata[7:0]);
        iss_f3.push_back(bus.mem_func3);
      end
      if (bus.rsp_valid === 1'b1) begin
        l = c; r = bus.rsp_rdata;
        if (bus.stall !== 1'b0) ok = 1'b0;
      end else if (bus.stall !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
      if (l >= 0) break;
    end
    if (we && f3 != 3'b111 && l >= 0)
      for (int i = 0; i < size_of(f3); i++) ref_mem[addr + 64'(i)] = wdata[8*i +: 8];
  endtask

  task automatic idle_cycle();
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 64'h301;
    bus.req_wdata = 64'd0; bus.req_func3 = 3'b011;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.rsp_valid, bus.mem_we, bus.mem_re} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: stall/rsp/we/re=%b required 0000",
               {bus.stall, bus.rsp_valid, bus.mem_we, bus.mem_re});
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.rsp_valid, bus.mem_we, bus.mem_re} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_outputs: stall/rsp/we/re=%b required 0000",
               {bus.stall, bus.rsp_valid, bus.mem_we, bus.mem_re});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_aligned_ld();
    run_req(1'b1, 64'h100, 64'h1122334455667788, 3'b011, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (lat !== 0 || f_we !== 1'b1) begin
      errors++; $display("FAIL sd_aligned: lat=%0d we=%b required 0 1", lat, f_we);
    end
    run_req(1'b0, 64'h100, 64'd0, 3'b011, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (f_re !== 1'b1 || st_ok !== 1'b1) begin
      errors++; $display("FAIL ld_cycle0: re=%b stall_ok=%b required 1 1", f_re, st_ok);
    end
    checks++;
    if (lat !== 1 || rd !== 64'h1122334455667788) begin
      errors++; $display("FAIL ld_aligned: lat=%0d data=%h required 1 1122334455667788", lat, rd);
    end
    idle_cycle();
  endtask

  task automatic test_misaligned_sw();
    logic [7:0] exp_b [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    run_req(1'b1, 64'h103, 64'hAABBCCDD, 3'b010, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (lat !== 3 || st_ok !== 1'b1 || iss_addr.size() != 4) begin
      errors++;
      $display("FAIL sw_split: lat=%0d stall_ok=%b beats=%0d required 3 1 4", lat, st_ok, iss_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (iss_addr[i] !== 64'h103 + 64'(i) || iss_byte[i] !== exp_b[i] || iss_f3[i] !== 3'b000) begin
          errors++;
          $display("FAIL sw_beat%0d: addr=%h byte=%h f3=%b required %h %h 000",
                   i, iss_addr[i], iss_byte[i], iss_f3[i], 64'h103 + 64'(i), exp_b[i]);
        end
      end
    end
    idle_cycle();
  endtask

  task automatic test_misaligned_lh();
    run_req(1'b1, 64'h107, 64'h34, 3'b000, lat, rd, st_ok, f_re, f_we);
    run_req(1'b1, 64'h108, 64'h80, 3'b000, lat, rd, st_ok, f_re, f_we);
    run_req(1'b0, 64'h107, 64'd0, 3'b001, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (lat !== 2 || rd !== 64'hFFFFFFFFFFFF8034 || st_ok !== 1'b1) begin
      errors++;
      $display("FAIL lh_split: lat=%0d data=%h stall_ok=%b required 2 ffffffffffff8034 1", lat, rd, st_ok);
    end
    run_req(1'b0, 64'h107, 64'd0, 3'b101, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (lat !== 2 || rd !== 64'h8034) begin
      errors++; $display("FAIL lhu_split: lat=%0d data=%h required 2 8034", lat, rd);
    end
    idle_cycle();
  endtask

  task automatic test_wrap();
    logic [63:0] a = 64'hFFFFFFFFFFFFFFFE;
    logic [63:0] wd = {32'd0, $urandom};
    logic [63:0] exp_d;
    run_req(1'b1, a, wd, 3'b010, lat, rd, st_ok, f_re, f_we);
    exp_d = load_ref(a, 3'b010);
    run_req(1'b0, a, 64'd0, 3'b010, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (lat !== 4 || rd !== exp_d || iss_addr.size() != 4) begin
      errors++;
      $display("FAIL lw_wrap: lat=%0d data=%h beats=%0d required 4 %h 4", lat, rd, iss_addr.size(), exp_d);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (iss_addr[i] !== a + 64'(i) || iss_f3[i] !== 3'b100) begin
          errors++;
          $display("FAIL wrap_addr%0d: addr=%h f3=%b required %h 100", i, iss_addr[i], iss_f3[i], a + 64'(i));
        end
      end
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_split();
    logic [63:0] wd = 64'h0123456789ABCDEF;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 64'h201;
    bus.req_wdata = wd; bus.req_func3 = 3'b011;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 64'h201) begin
      errors++; $display("FAIL sd_byte0: we=%b addr=%h required 1 201", bus.mem_we, bus.mem_addr);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.rsp_valid, bus.mem_we} !== 3'b000) begin
      errors++; $display("FAIL rst_midsplit: stall/rsp/we=%b required 000", {bus.stall, bus.rsp_valid, bus.mem_we});
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.mem_we, bus.mem_re} !== 3'b000) begin
      errors++; $display("FAIL post_rst_idle: stall/we/re=%b required 000", {bus.stall, bus.mem_we, bus.mem_re});
    end
    @(posedge clk); #1;
    run_req(1'b1, 64'h201, wd, 3'b011, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (lat !== 7 || st_ok !== 1'b1 || iss_addr.size() != 8 || iss_addr[0] !== 64'h201) begin
      errors++;
      $display("FAIL sd_restart: lat=%0d stall_ok=%b beats=%0d required 7 1 8", lat, st_ok, iss_addr.size());
    end
    run_req(1'b0, 64'h201, 64'd0, 3'b011, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (lat !== 8 || rd !== wd) begin
      errors++; $display("FAIL ld_restart: lat=%0d data=%h required 8 %h", lat, rd, wd);
    end
    idle_cycle();
  endtask

  task automatic test_illegal_back_to_back();
    run_req(1'b0, 64'h400, 64'd0, 3'b111, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (lat !== 0 || rd !== 64'd0 || iss_addr.size() != 0 || st_ok !== 1'b1) begin
      errors++;
      $display("FAIL illegal: lat=%0d data=%h beats=%0d stall_ok=%b required 0 0 0 1", lat, rd, iss_addr.size(), st_ok);
    end
    run_req(1'b1, 64'h410, 64'h9C, 3'b000, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (lat !== 0 || f_we !== 1'b1 || st_ok !== 1'b1) begin
      errors++; $display("FAIL b2b_sb: lat=%0d we=%b stall_ok=%b required 0 1 1", lat, f_we, st_ok);
    end
    run_req(1'b0, 64'h410, 64'd0, 3'b000, lat, rd, st_ok, f_re, f_we);
    checks++;
    if (lat !== 1 || f_re !== 1'b1 || rd !== 64'hFFFFFFFFFFFFFF9C) begin
      errors++; $display("FAIL b2b_lb: lat=%0d re=%b data=%h required 1 1 ffffffffffffff9c", lat, f_re, rd);
    end
    idle_cycle();
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [63:0] a, wd, exp_d;
    int          el;
    for (int t = 0; t < 60; t++) begin
      a  = 64'h300 + 64'($urandom_range(0, 63));
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) f3 = 3'b111;
      wd = {$urandom, $urandom};
      exp_d = (we || f3 == 3'b111) ? 64'd0 : load_ref(a, f3);
      el = exp_lat(we, a, f3);
      run_req(we, a, wd, f3, lat, rd, st_ok, f_re, f_we);
      checks++;
      if (lat !== el || rd !== exp_d || st_ok !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d we=%b f3=%b addr=%h: lat=%0d data=%h stall_ok=%b required %0d %h 1",
                 t, we, f3, a, lat, rd, st_ok, el, exp_d);
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    foreach (ref_mem[k]) begin
      checks++;
      if (rd_phys(k) !== ref_mem[k]) begin
        errors++; $display("FAIL mem_image addr=%h: got %h required %h", k, rd_phys(k), ref_mem[k]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned_ld();
    test_misaligned_sw();
    test_misaligned_lh();
    test_wrap();
    test_reset_mid_split();
    test_illegal_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
